// File: rtl/svm_stage_engine.sv
// svm_stage_engine: single-stage SVM classifier with linear kernel accumulation.
// Pixels stream in one beat per cycle. Each beat feeds NUM_OF_SV parallel
// multiply-accumulate channels. A serial reduce chain then weights each kernel
// sum by its alpha and adds it to the bias, one channel per cycle.
// Optional feature: define SVM_MARGIN_EN to build the |score| >= MARGIN
// confidence comparator. Without it, confident is tied high outside reset.
module svm_stage_engine #(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 30,
  parameter int NUM_OF_SV     = 10,
  parameter int ALPHA_W       = 16,
  parameter int MARGIN        = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   pix_valid,
  output logic                                   pix_ready,
  input  logic [XLEN_PIXEL-1:0]                  x_test,
  input  logic [NUM_OF_SV*XLEN_PIXEL-1:0]        x_sv,
  input  logic [NUM_OF_SV*ALPHA_W-1:0]           alpha,
  input  logic signed [ALPHA_W-1:0]              bias,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   y_class,
  output logic signed [4*XLEN_PIXEL+ALPHA_W+$clog2(NUM_OF_SV):0] score,
  output logic                                   confident
);

  localparam int ACC_W   = 4 * XLEN_PIXEL;
  localparam int SCORE_W = 4 * XLEN_PIXEL + ALPHA_W + $clog2(NUM_OF_SV) + 1;
  // One channel product: zero-extended kernel sum times signed alpha.
  localparam int PROD_W  = ACC_W + 1 + ALPHA_W;
  localparam int CNT_W   = $clog2(NUM_OF_PIXELS + 1);
  localparam int CH_W    = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;

  typedef enum logic [1:0] {IDLE, MAC, REDUCE, DONE} state_t;

  state_t                     state_reg;
  logic [ACC_W-1:0]           acc_reg [NUM_OF_SV];
  logic [CNT_W-1:0]           pix_cnt_reg;
  logic [CH_W-1:0]            ch_reg;
  logic signed [SCORE_W-1:0]  sum_reg;
  logic signed [SCORE_W-1:0]  score_reg;

  logic [XLEN_PIXEL-1:0]      sv_pix   [NUM_OF_SV];
  logic signed [ALPHA_W-1:0]  alpha_ch [NUM_OF_SV];
  logic [2*XLEN_PIXEL-1:0]    prod     [NUM_OF_SV];

  // Unpack the per-channel buses and form the pixel products in parallel.
  generate
    for (genvar gi = 0; gi < NUM_OF_SV; gi++) begin : g_ch
      assign sv_pix[gi]   = x_sv[gi*XLEN_PIXEL +: XLEN_PIXEL];
      assign alpha_ch[gi] = alpha[gi*ALPHA_W +: ALPHA_W];
      assign prod[gi]     = {{XLEN_PIXEL{1'b0}}, x_test} * {{XLEN_PIXEL{1'b0}}, sv_pix[gi]};
    end
  endgenerate

  logic                       accept;
  logic                       beat_last;
  logic signed [ALPHA_W-1:0]  alpha_sel;
  logic signed [PROD_W-1:0]   acc_s;
  logic signed [PROD_W-1:0]   alpha_s;
  logic signed [PROD_W-1:0]   term;
  logic signed [SCORE_W-1:0]  sum_next;

  assign accept    = pix_valid && pix_ready;
  assign beat_last = accept && (pix_cnt_reg == CNT_W'(NUM_OF_PIXELS - 1));

  // Reduce datapath: the tail of the accumulator chain times the matching alpha.
  always_comb begin
    alpha_sel = alpha_ch[ch_reg];
    acc_s     = PROD_W'($signed({1'b0, acc_reg[NUM_OF_SV-1]}));
    alpha_s   = PROD_W'(alpha_sel);
    term      = acc_s * alpha_s;
    sum_next  = sum_reg + SCORE_W'(term);
  end

  // Control FSM, kernel accumulators, reduce chain and result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      pix_cnt_reg <= '0;
      ch_reg      <= '0;
      sum_reg     <= '0;
      score_reg   <= '0;
      for (int i = 0; i < NUM_OF_SV; i++) acc_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= MAC;
            pix_cnt_reg <= '0;
            for (int i = 0; i < NUM_OF_SV; i++) acc_reg[i] <= '0;
          end
        end
        MAC: begin
          if (accept) begin
            for (int i = 0; i < NUM_OF_SV; i++) acc_reg[i] <= acc_reg[i] + ACC_W'(prod[i]);
            pix_cnt_reg <= pix_cnt_reg + 1'b1;
            if (beat_last) begin
              state_reg <= REDUCE;
              sum_reg   <= SCORE_W'(bias);
              ch_reg    <= CH_W'(NUM_OF_SV - 1);
            end
          end
        end
        REDUCE: begin
          for (int i = 1; i < NUM_OF_SV; i++) acc_reg[i] <= acc_reg[i-1];
          acc_reg[0] <= '0;
          sum_reg    <= sum_next;
          ch_reg     <= ch_reg - 1'b1;
          if (ch_reg == '0) begin
            state_reg <= DONE;
            score_reg <= sum_next;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Status outputs are forced low while reset is held.
  assign pix_ready = rst && (state_reg == MAC);
  assign busy      = rst && (state_reg != IDLE);
  assign done      = rst && (state_reg == DONE);
  assign y_class   = rst && !score_reg[SCORE_W-1];
  assign score     = score_reg;

`ifdef SVM_MARGIN_EN
  logic [SCORE_W-1:0] score_mag;
  assign score_mag = score_reg[SCORE_W-1] ? -score_reg : score_reg;
  assign confident = rst && (score_mag >= SCORE_W'(MARGIN));
`else
  // Always confident; MARGIN is referenced only to keep it a live parameter.
  assign confident = rst && (MARGIN >= 0 || MARGIN < 0);
`endif

endmodule

// File: tb/tb_svm_stage_engine.sv
// tb_svm_stage_engine: directed self-checking bench for svm_stage_engine.
// A dot-product model computes the expected score from the stored stimulus.
// A per-cycle monitor checks busy, done, pix_ready and the result fields.
module tb_svm_stage_engine;

  localparam int XP        = 8;
  localparam int NP        = 30;
  localparam int NSV       = 10;
  localparam int AW        = 16;
  localparam int TB_MARGIN = 500;
  localparam int SW        = 4*XP + AW + $clog2(NSV) + 1;
  localparam int BIG       = 1 << 30;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic                  pix_valid = 1'b0;
  logic                  pix_ready;
  logic [XP-1:0]         x_test = '0;
  logic [NSV*XP-1:0]     x_sv = '0;
  logic [NSV*AW-1:0]     alpha = '0;
  logic signed [AW-1:0]  bias = '0;
  logic                  busy, done, y_class, confident;
  logic signed [SW-1:0]  score;

  svm_stage_engine #(
    .XLEN_PIXEL(XP), .NUM_OF_PIXELS(NP), .NUM_OF_SV(NSV), .ALPHA_W(AW), .MARGIN(TB_MARGIN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .x_test(x_test), .x_sv(x_sv), .alpha(alpha), .bias(bias), .busy(busy), .done(done),
    .y_class(y_class), .score(score), .confident(confident)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Stimulus and model state
  int     xt [NP];
  int     xs [NP][NSV];
  int     al [NSV];
  int     bs;
  longint exp_score;
  bit     exp_yc, exp_conf;

  // Expected timing windows
  int exp_done_cyc = -1;
  int busy_lo = BIG, busy_hi = -1, mac_hi = -1;
  int acc_cnt = 0;
  int done_cnt = 0, done_seen_cyc = -1;
  longint last_score = 0;
  bit last_yc = 1'b0, last_conf = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Score = bias + sum over SVs of alpha * <x_test, x_sv>
  function automatic longint model_score();
    longint s, k;
    s = bs;
    for (int i = 0; i < NSV; i++) begin
      k = 0;
      for (int p = 0; p < NP; p++) k += longint'(xt[p]) * longint'(xs[p][i]);
      s += longint'(al[i]) * k;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_uniform(input int t, input int v, input int a, input int b);
    for (int p = 0; p < NP; p++) begin
      xt[p] = t;
      for (int i = 0; i < NSV; i++) xs[p][i] = v;
    end
    for (int i = 0; i < NSV; i++) al[i] = a;
    bs = b;
  endtask

  task automatic load_varied();
    for (int p = 0; p < NP; p++) begin
      xt[p] = (p*37 + 11) % 256;
      for (int i = 0; i < NSV; i++) xs[p][i] = (p*13 + i*29 + 7) % 256;
    end
    for (int i = 0; i < NSV; i++) al[i] = ((i % 2) != 0 ? -1 : 1) * (i*3001 + 17);
    bs = -1234;
  endtask

  // Per-cycle monitor: compares the handshake, status and result against expectations.
  always @(negedge clk) begin
    bit eb, er, ed;
    eb = rst && cyc >= busy_lo && cyc <= busy_hi;
    er = rst && cyc >= busy_lo && cyc <= mac_hi;
    ed = rst && cyc == exp_done_cyc;
    check("busy", busy, eb);
    check("pix_ready", pix_ready, er);
    check("done", done, ed);
    if (!rst) begin
      check("rst_y_class", y_class, 0);
      check("rst_confident", confident, 0);
    end
    if (done) begin
      done_cnt++;
      done_seen_cyc = cyc;
      last_score = score;
      last_yc = y_class;
      last_conf = confident;
    end
    if (ed) begin
      check("score", score, exp_score);
      check("y_class", y_class, exp_yc);
      check("confident", confident, exp_conf);
    end
    if (rst && pix_valid && pix_ready) begin
      acc_cnt++;
      if (acc_cnt == NP) begin
        mac_hi = cyc;
        exp_done_cyc = cyc + NSV + 1;
        busy_hi = exp_done_cyc;
      end
    end
  end

  task automatic run(input bit toggle, input bit start_mid, input bit start_done, input int abort_at);
    int slot;
    int guard;
    for (int i = 0; i < NSV; i++) alpha[i*AW +: AW] = AW'(al[i]);
    bias = AW'(bs);
    exp_score = model_score();
    exp_yc = (exp_score >= 0);
`ifdef SVM_MARGIN_EN
    exp_conf = ((exp_score < 0 ? -exp_score : exp_score) >= TB_MARGIN);
`else
    exp_conf = 1'b1;
`endif
    acc_cnt = 0;
    exp_done_cyc = -1;
    done_seen_cyc = -1;
    mac_hi = BIG;
    busy_hi = BIG;
    busy_lo = cyc + 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    slot = 0;
    while (acc_cnt < NP && slot < 200) begin
      if (abort_at >= 0 && acc_cnt == abort_at) begin
        rst = 1'b0;
        pix_valid = 1'b1;
        x_test = '1;
        busy_lo = BIG;
        tick();
        rst = 1'b1;
        pix_valid = 1'b0;
        check("reset_score_cleared", score, 0);
        repeat (3) tick();
        return;
      end
      x_test = XP'(xt[acc_cnt]);
      for (int i = 0; i < NSV; i++) x_sv[i*XP +: XP] = XP'(xs[acc_cnt][i]);
      pix_valid = toggle ? (slot % 2 == 0) : 1'b1;
      start = start_mid && (slot == 5);
      tick();
      slot++;
    end
    start = 1'b0;
    check("beats_accepted", acc_cnt, NP);
    check("beat_slots", slot, toggle ? 2*NP - 1 : NP);
    // Junk beats during REDUCE/DONE must be ignored.
    pix_valid = 1'b1;
    x_test = '1;
    x_sv = '1;
    guard = 0;
    while (cyc < exp_done_cyc && guard < 100) begin
      tick();
      guard++;
    end
    start = start_done;
    tick();
    start = 1'b0;
    pix_valid = 1'b0;
    repeat (3) tick();
    check("done_latency", done_seen_cyc - mac_hi, NSV + 1);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // All-ones stimulus with unit alphas gives 30*10.
    load_uniform(1, 1, 1, 0);
    run(0, 0, 0, -1);
    check("req041_score", last_score, 300);
    check("req041_y_class", last_yc, 1);
    check("req041_latency", done_seen_cyc - mac_hi, 11);
`ifdef SVM_MARGIN_EN
    check("req046_confident", last_conf, (TB_MARGIN <= 300) ? 1 : 0);
`endif

    // Negative alphas with positive bias.
    load_uniform(1, 1, -1, 5);
    run(0, 0, 0, -1);
    check("req042_score", last_score, -295);
    check("req042_y_class", last_yc, 0);

    // pix_valid toggling every other cycle.
    load_uniform(1, 1, 1, 0);
    run(1, 0, 0, -1);
    check("req043_score", last_score, 300);

    // Reset mid-MAC aborts without done, then a full run.
    load_uniform(2, 3, 1, 0);
    run(0, 0, 0, 12);
    check("req044_no_done", done_cnt, 3);
    run(0, 0, 0, -1);
    check("req044_score", last_score, 1800);

    // Start pulses during MAC and during done must not restart.
    load_varied();
    run(0, 1, 1, -1);

    // Extreme magnitudes, both signs.
    load_uniform(255, 255, -32768, -32768);
    run(0, 0, 0, -1);
    check("max_neg_score", last_score, -64'sd639221792768);
    load_uniform(255, 255, 32767, 32767);
    run(0, 0, 0, -1);
    check("max_pos_score", last_score, 64'sd639202285267);

    check("total_dones", done_cnt, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
